// File: rtl/controle_multiciclo_if.sv
// Control bus of the multi-cycle control unit.
// Purpose: bundles the opcode/memory-ready inputs and all control strobes,
//          the debug state and the retired-instruction count.
// Ports (signals):
//   CODOP      opcode from the instruction register (master -> slave)
//   MEMPRONTO  memory ready                          (master -> slave)
//   ESCCONDCP, ESCCP, FONTECP, ESCREG, LERMEM, ESCMEM, ESCIR, IOUD,
//   MEMPARAREG control strobes                       (slave -> master)
//   ESTADO     current state for debug               (slave -> master)
//   NINSTR     retired-instruction count             (slave -> master)
interface controle_multiciclo_if #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
) ();
    logic [OPW-1:0]  CODOP;
    logic            MEMPRONTO;
    logic            ESCCONDCP;
    logic            ESCCP;
    logic [1:0]      FONTECP;
    logic            ESCREG;
    logic            LERMEM;
    logic            ESCMEM;
    logic            ESCIR;
    logic            IOUD;
    logic            MEMPARAREG;
    logic [2:0]      ESTADO;
    logic [CNTW-1:0] NINSTR;

    modport master (
        output CODOP, MEMPRONTO,
        input  ESCCONDCP, ESCCP, FONTECP, ESCREG, LERMEM, ESCMEM, ESCIR,
               IOUD, MEMPARAREG, ESTADO, NINSTR
    );

    modport slave (
        input  CODOP, MEMPRONTO,
        output ESCCONDCP, ESCCP, FONTECP, ESCREG, LERMEM, ESCMEM, ESCIR,
               IOUD, MEMPARAREG, ESTADO, NINSTR
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit for the TP processor datapath.
// Purpose: sequences each instruction through fetch, decode, execute, memory
//          and write-back, waiting on the memory-ready handshake, and counts
//          retired instructions (saturating). A halt opcode parks the unit
//          until reset.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  control bus (slave side): CODOP/MEMPRONTO in, strobes, ESTADO and
//        NINSTR out
module controle_multiciclo #(
    parameter int             OPW     = 4,
    parameter int             CNTW    = 16,
    parameter logic [OPW-1:0] OP_LW   = 4'b1000,
    parameter logic [OPW-1:0] OP_SW   = 4'b1001,
    parameter logic [OPW-1:0] OP_J    = 4'b1011,
    parameter logic [OPW-1:0] OP_BEQ  = 4'b1100,
    parameter logic [OPW-1:0] OP_HALT = 4'b1110,
    parameter logic [OPW-1:0] OP_NOP  = 4'b1111
) (
    input  logic                  CLK,
    input  logic                  RST,
    controle_multiciclo_if.slave  bus
);

    typedef enum logic [2:0] {
        BUSCA   = 3'd0,
        DECOD   = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        ESCRITA = 3'd4,
        PARADO  = 3'd5
    } estado_t;

    estado_t         state_q, state_d;
    logic [OPW-1:0]  opreg_q, opreg_d;
    logic [CNTW-1:0] ninstr_q, ninstr_d;
    logic            retire_s;

    logic            esccondcp_s;
    logic            esccp_s;
    logic [1:0]      fontecp_s;
    logic            escreg_s;
    logic            lermem_s;
    logic            escmem_s;
    logic            escir_s;
    logic            ioud_s;
    logic            memparareg_s;

    // State, latched opcode and retired counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= BUSCA;
            opreg_q  <= {OPW{1'b0}};
            ninstr_q <= {CNTW{1'b0}};
        end else begin
            state_q  <= state_d;
            opreg_q  <= opreg_d;
            ninstr_q <= ninstr_d;
        end
    end

    // Next-state, opcode capture and strobe decode
    always_comb begin
        state_d      = state_q;
        opreg_d      = opreg_q;
        retire_s     = 1'b0;
        esccondcp_s  = 1'b0;
        esccp_s      = 1'b0;
        fontecp_s    = 2'b00;
        escreg_s     = 1'b0;
        lermem_s     = 1'b0;
        escmem_s     = 1'b0;
        escir_s      = 1'b0;
        ioud_s       = 1'b0;
        memparareg_s = 1'b0;
        case (state_q)
            BUSCA: begin
                lermem_s = 1'b1;
                // IR load and PC+1 happen together on the completing fetch
                escir_s  = bus.MEMPRONTO;
                esccp_s  = bus.MEMPRONTO;
                if (bus.MEMPRONTO) begin
                    state_d = DECOD;
                end else begin
                    state_d = BUSCA;
                end
            end
            DECOD: begin
                // Every exit from DECOD captures the opcode so later states
                // no longer depend on CODOP
                opreg_d = bus.CODOP;
                if (bus.CODOP == OP_NOP) begin
                    state_d  = BUSCA;
                    retire_s = 1'b1;
                end else if (bus.CODOP == OP_HALT) begin
                    state_d = PARADO;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (opreg_q == OP_J) begin
                    esccp_s   = 1'b1;
                    fontecp_s = 2'b10;
                    state_d   = BUSCA;
                    retire_s  = 1'b1;
                end else if (opreg_q == OP_BEQ) begin
                    esccondcp_s = 1'b1;
                    fontecp_s   = 2'b01;
                    state_d     = BUSCA;
                    retire_s    = 1'b1;
                end else if ((opreg_q == OP_LW) || (opreg_q == OP_SW)) begin
                    state_d = MEM;
                end else begin
                    state_d = ESCRITA;
                end
            end
            MEM: begin
                ioud_s   = 1'b1;
                lermem_s = (opreg_q == OP_LW);
                escmem_s = (opreg_q == OP_SW);
                if (!bus.MEMPRONTO) begin
                    state_d = MEM;
                end else if (opreg_q == OP_LW) begin
                    state_d = ESCRITA;
                end else begin
                    state_d  = BUSCA;
                    retire_s = 1'b1;
                end
            end
            ESCRITA: begin
                escreg_s     = 1'b1;
                memparareg_s = (opreg_q == OP_LW);
                state_d      = BUSCA;
                retire_s     = 1'b1;
            end
            PARADO: begin
                state_d = PARADO;
            end
            default: begin
                // Unused encodings recover to fetch
                state_d = BUSCA;
            end
        endcase
    end

    // Saturating retired-instruction counter
    always_comb begin
        ninstr_d = ninstr_q;
        if (retire_s && (ninstr_q != {CNTW{1'b1}})) begin
            ninstr_d = ninstr_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            ninstr_d = ninstr_q;
        end
    end

    // Strobes are masked during reset so no partial write survives
    assign bus.ESCCONDCP  = esccondcp_s  & ~RST;
    assign bus.ESCCP      = esccp_s      & ~RST;
    assign bus.FONTECP    = fontecp_s    & {2{~RST}};
    assign bus.ESCREG     = escreg_s     & ~RST;
    assign bus.LERMEM     = lermem_s     & ~RST;
    assign bus.ESCMEM     = escmem_s     & ~RST;
    assign bus.ESCIR      = escir_s      & ~RST;
    assign bus.IOUD       = ioud_s       & ~RST;
    assign bus.MEMPARAREG = memparareg_s & ~RST;
    assign bus.ESTADO     = state_q;
    assign bus.NINSTR     = ninstr_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Testbench for controle_multiciclo: random instruction stream with an
// instruction-level reference model and a scoreboard, plus directed reset,
// halt and counter-saturation scenarios.
module tb_controle_multiciclo;

    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_J    = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    controle_multiciclo_if #(.OPW(4), .CNTW(16)) bus ();
    controle_multiciclo_if #(.OPW(4), .CNTW(2))  bus2 ();

    controle_multiciclo #(.OPW(4), .CNTW(16)) dut (
        .CLK(clk), .RST(rst), .bus(bus));
    controle_multiciclo #(.OPW(4), .CNTW(2)) dut_sat (
        .CLK(clk), .RST(rst2), .bus(bus2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction-level observation / expectation record
    typedef struct {
        int          cycles;
        logic [63:0] trace;
        int          fetch;
        int          escir;
        int          jump;
        int          branch;
        int          escreg;
        int          memreg;
        int          lermem;
        int          escmem;
        int          ioud;
        int          ninstr;
    } rec_t;

    rec_t exp_q[$];
    rec_t acc;
    bit   have_acc = 1'b0;
    bit   mon_en   = 1'b0;
    logic [2:0] prev_st = 3'd0;
    int   exp_n = 0;
    bit   sat_done = 1'b0;

    function automatic logic [9:0] strobes();
        return {bus.ESCCONDCP, bus.ESCCP, bus.FONTECP, bus.ESCREG, bus.LERMEM,
                bus.ESCMEM, bus.ESCIR, bus.IOUD, bus.MEMPARAREG};
    endfunction

    task automatic add_sample();
        acc.cycles++;
        acc.trace = {acc.trace[60:0], bus.ESTADO};
        if (bus.ESCCP && bus.ESCIR && bus.FONTECP == 2'b00 && bus.LERMEM && !bus.IOUD) acc.fetch++;
        if (bus.ESCCP && !bus.ESCIR && bus.FONTECP == 2'b10) acc.jump++;
        if (bus.ESCCONDCP && !bus.ESCCP && bus.FONTECP == 2'b01) acc.branch++;
        acc.escir  += int'(bus.ESCIR);
        acc.escreg += int'(bus.ESCREG);
        acc.memreg += int'(bus.MEMPARAREG);
        acc.lermem += int'(bus.LERMEM);
        acc.escmem += int'(bus.ESCMEM);
        acc.ioud   += int'(bus.IOUD);
    endtask

    task automatic compare_rec();
        rec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got cycles=%0d expected none", acc.cycles);
        end else begin
            e = exp_q.pop_front();
            check("cycles", acc.cycles, e.cycles);
            check("state_trace", acc.trace, e.trace);
            check("fetch_pc1", acc.fetch, e.fetch);
            check("escir_pulses", acc.escir, e.escir);
            check("jump_write", acc.jump, e.jump);
            check("branch_write", acc.branch, e.branch);
            check("escreg", acc.escreg, e.escreg);
            check("memparareg", acc.memreg, e.memreg);
            check("lermem", acc.lermem, e.lermem);
            check("escmem", acc.escmem, e.escmem);
            check("ioud", acc.ioud, e.ioud);
            check("ninstr", acc.ninstr, e.ninstr);
        end
    endtask

    // Monitor: an instruction ends when the state returns to fetch
    always @(negedge clk) begin
        if (!mon_en) begin
            have_acc = 1'b0;
        end else begin
            if (have_acc && bus.ESTADO == 3'd0 && prev_st != 3'd0) begin
                acc.ninstr = int'(bus.NINSTR);
                compare_rec();
                have_acc = 1'b0;
            end
            if (!have_acc) begin
                acc = '{default: 0};
                have_acc = 1'b1;
            end
            add_sample();
            prev_st = bus.ESTADO;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: shape of one instruction from the opcode rules
    task automatic run_instr(input logic [3:0] op, input int wb, input int wm);
        rec_t e;
        bit is_ls, is_lw, is_sw, writes;
        is_lw  = (op == OP_LW);
        is_sw  = (op == OP_SW);
        is_ls  = is_lw || is_sw;
        writes = is_lw || !(is_sw || op == OP_J || op == OP_BEQ || op == OP_NOP);
        e = '{default: 0};
        for (int i = 0; i <= wb; i++) e.trace = {e.trace[60:0], 3'd0};
        e.trace = {e.trace[60:0], 3'd1};
        if (op != OP_NOP) e.trace = {e.trace[60:0], 3'd2};
        if (is_ls) for (int i = 0; i <= wm; i++) e.trace = {e.trace[60:0], 3'd3};
        if (writes) e.trace = {e.trace[60:0], 3'd4};
        e.cycles = (wb + 1) + 1 + ((op != OP_NOP) ? 1 : 0) + (is_ls ? wm + 1 : 0) + (writes ? 1 : 0);
        e.fetch  = 1;
        e.escir  = 1;
        e.jump   = (op == OP_J) ? 1 : 0;
        e.branch = (op == OP_BEQ) ? 1 : 0;
        e.escreg = writes ? 1 : 0;
        e.memreg = is_lw ? 1 : 0;
        e.lermem = (wb + 1) + (is_lw ? wm + 1 : 0);
        e.escmem = is_sw ? wm + 1 : 0;
        e.ioud   = is_ls ? wm + 1 : 0;
        exp_n    = (exp_n == 65535) ? exp_n : exp_n + 1;
        e.ninstr = exp_n;
        exp_q.push_back(e);
        // Drive the cycle schedule; don't-care inputs are randomized
        for (int i = 0; i <= wb; i++) begin
            bus.CODOP = 4'($urandom);
            bus.MEMPRONTO = (i == wb);
            step();
        end
        bus.CODOP = op;
        bus.MEMPRONTO = 1'($urandom);
        step();
        if (op != OP_NOP) begin
            bus.CODOP = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            bus.MEMPRONTO = 1'($urandom);
            step();
        end
        if (is_ls) begin
            for (int i = 0; i <= wm; i++) begin
                bus.CODOP = 4'($urandom);
                bus.MEMPRONTO = (i == wm);
                step();
            end
        end
        if (writes) begin
            bus.CODOP = 4'($urandom);
            bus.MEMPRONTO = 1'($urandom);
            step();
        end
    endtask

    function automatic logic [3:0] rand_op();
        int r;
        int a;
        r = $urandom_range(0, 5);
        case (r)
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_J;
            3: return OP_BEQ;
            4: return OP_NOP;
            default: begin
                a = $urandom_range(0, 9);
                if (a < 8) return 4'(a);
                else if (a == 8) return 4'b1010;
                else return 4'b1101;
            end
        endcase
    endfunction

    // Saturation scenario on the narrow-counter instance
    initial begin
        int sat_exp;
        rst2 = 1'b1;
        bus2.CODOP = OP_NOP;
        bus2.MEMPRONTO = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            repeat (2) @(posedge clk);
            #1;
            sat_exp = (j < 3) ? j : 3;
            check("sat_state", bus2.ESTADO, 3'd0);
            check("sat_ninstr", bus2.NINSTR, sat_exp);
        end
        sat_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst = 1'b1;
        bus.CODOP = 4'b0000;
        bus.MEMPRONTO = 1'b0;
        #3;
        check("reset_estado", bus.ESTADO, 3'd0);
        check("reset_strobes", strobes(), 10'd0);
        check("reset_ninstr", bus.NINSTR, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        exp_n = 0;
        #1;
        check("first_fetch_lermem", bus.LERMEM, 1'b1);

        run_instr(4'b0010, 0, 0);
        run_instr(OP_LW, 2, 3);
        run_instr(OP_J, 0, 0);
        run_instr(OP_BEQ, 1, 0);
        run_instr(OP_NOP, 0, 0);
        for (int k = 0; k < 40; k++)
            run_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));

        // HALT: fetch cycle closes the previous instruction, then park
        bus.CODOP = 4'($urandom);
        bus.MEMPRONTO = 1'b1;
        step();
        mon_en = 1'b0;
        bus.CODOP = OP_HALT;
        step();
        for (int k = 0; k < 20; k++) begin
            bus.CODOP = 4'($urandom);
            bus.MEMPRONTO = 1'($urandom);
            @(negedge clk);
            check("halt_estado", bus.ESTADO, 3'd5);
            check("halt_strobes", strobes(), 10'd0);
            check("halt_ninstr", bus.NINSTR, exp_n);
            step();
        end

        // Leave halt through reset, retire two instructions, then reset mid-LW
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_n = 0;
        mon_en = 1'b1;
        run_instr(OP_NOP, 0, 0);
        run_instr(4'b0101, 1, 0);
        bus.CODOP = 4'($urandom);
        bus.MEMPRONTO = 1'b1;
        step();
        mon_en = 1'b0;
        bus.CODOP = OP_LW;
        step();
        bus.CODOP = 4'b0000;
        bus.MEMPRONTO = 1'b0;
        step();
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.ESTADO == 3'd3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("reach_mem_state", found, 1'b1);
        check("pre_reset_ninstr", bus.NINSTR, 16'd2);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_estado", bus.ESTADO, 3'd0);
        check("async_rst_lermem", bus.LERMEM, 1'b0);
        check("async_rst_strobes", strobes(), 10'd0);
        check("async_rst_ninstr", bus.NINSTR, 16'd0);
        step();
        rst = 1'b0;
        exp_n = 0;
        mon_en = 1'b1;
        #1;
        check("post_rst_lermem", bus.LERMEM, 1'b1);
        for (int k = 0; k < 15; k++)
            run_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));

        // One stalled fetch cycle closes the last instruction
        bus.CODOP = 4'($urandom);
        bus.MEMPRONTO = 1'b0;
        step();
        mon_en = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);

        for (int k = 0; k < 100 && !sat_done; k++) step();
        check("sat_scenario_done", sat_done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle control unit for the TP processor datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states, waiting on a memory-ready handshake. It drives the PC write, PC source, register write, memory and IR strobes from a latched opcode. Opcode width and opcode values are parameters, and a retired-instruction counter and a halt state are provided.

## Interface
- OPW, 4, opcode width in bits
- CNTW, 16, retired-instruction counter width
- OP_LW, 4'b1000, load word (OPW bits)
- OP_SW, 4'b1001, store word
- OP_J, 4'b1011, unconditional jump
- OP_BEQ, 4'b1100, branch if equal
- OP_HALT, 4'b1110, stop sequencing
- OP_NOP, 4'b1111, no operation, no register write
- Any other opcode is an ALU (R-type) instruction.

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- CODOP  in  OPW  opcode field from the instruction register
- MEMPRONTO  in  1  memory ready (access completes this cycle)
- ESCCONDCP  out  1  conditional PC write (branch)
- ESCCP  out  1  unconditional PC write
- FONTECP  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target
- ESCREG  out  1  register file write
- LERMEM  out  1  memory read
- ESCMEM  out  1  memory write
- ESCIR  out  1  instruction register load
- IOUD  out  1  memory address source: 0 = PC, 1 = ALU result
- MEMPARAREG  out  1  write-back source: 1 = memory data, 0 = ALU
- ESTADO  out  3  current state, for debug
- NINSTR  out  CNTW  retired-instruction count

## Operation
- States (ESTADO encoding): BUSCA=0, DECOD=1, EXEC=2, MEM=3, ESCRITA=4, PARADO=5. Codes 6 and 7 go to BUSCA on the next edge.
- Internal register OPREG (OPW bits) captures CODOP on the clock edge that leaves DECOD. EXEC, MEM and ESCRITA decode from OPREG only, so CODOP may change after DECOD.
- Any output not listed for a state is 0.
- BUSCA:
  - LERMEM=1, IOUD=0, FONTECP=00.
  - ESCIR=ESCCP=MEMPRONTO.
  - Stays in BUSCA while MEMPRONTO=0; goes to DECOD when MEMPRONTO=1.
- DECOD, next state by CODOP:
  - OP_NOP: to BUSCA; instruction retires.
  - OP_HALT: to PARADO.
  - Any other opcode: to EXEC.
- EXEC, by OPREG:
  - OP_J: ESCCP=1, FONTECP=10; to BUSCA; retires.
  - OP_BEQ: ESCCONDCP=1, FONTECP=01; to BUSCA; retires.
  - OP_LW / OP_SW: to MEM.
  - ALU: to ESCRITA.
- MEM:
  - IOUD=1. LERMEM=1 for LW; ESCMEM=1 for SW.
  - Stays in MEM while MEMPRONTO=0.
  - When MEMPRONTO=1: LW goes to ESCRITA; SW goes to BUSCA and retires.
- ESCRITA: ESCREG=1, MEMPARAREG=1 for LW (0 otherwise); to BUSCA; retires.
- PARADO: all strobes 0; leaves only on RST.
- NINSTR:
  - Increments by 1 on each clock edge where an instruction retires.
  - Saturates at 2^CNTW-1.
  - HALT does not count.

## Timing
- Strobes are combinational from ESTADO, OPREG and MEMPRONTO; state, OPREG and NINSTR are registered.
- While RST=1, all strobes are forced to 0.
- On RST assertion, immediately and regardless of clock: ESTADO=BUSCA, OPREG=0, NINSTR=0. This also applies mid-instruction and mid-MEM wait; no partial write strobe survives.
- First fetch: BUSCA outputs appear in the first cycle after RST deasserts.
- Cycles per instruction with MEMPRONTO=1 in every memory cycle:
  - NOP 2; J and BEQ 3; ALU and SW 4; LW 5.
  - Each MEMPRONTO=0 cycle in BUSCA or MEM adds 1.
- MEMPRONTO is ignored outside BUSCA and MEM.

## Test plan
- Reset mid-LW:
  - Stimulus: assert RST while ESTADO=3 with MEMPRONTO=0.
  - Required: ESTADO=0, LERMEM=0 and NINSTR=0 immediately, with no clock edge needed.
  - After deassert: LERMEM=1 on the next cycle.
- ALU (4'b0010) with MEMPRONTO=1 throughout:
  - Required ESTADO sequence: 0,1,2,4,0.
  - ESCREG=1 only in state 4, with MEMPRONTO... MEMPARAREG=0.
  - NINSTR goes 0→1.
- LW with MEMPRONTO low for 2 cycles in BUSCA and 3 cycles in MEM:
  - Required: 10 cycles total.
  - ESCIR pulses once; ESCREG=1 with MEMPARAREG=1 in the last cycle.
- J followed by BEQ:
  - J: ESCCP=1 with FONTECP=10 in EXEC.
  - BEQ: ESCCONDCP=1 with FONTECP=01 and ESCCP=0 in EXEC.
  - CODOP toggled to 4'b0000 during EXEC: outputs unaffected.
- NOP then HALT:
  - NOP: 2 cycles, ESCREG never 1, NINSTR increments.
  - HALT: ESTADO=5 held for 20 cycles with all strobes 0 and NINSTR unchanged.
- CNTW=2: execute 5 NOPs; NINSTR reads 1,2,3,3,3 (saturates).
